trap_event_logger: RTL and testbench

// Synthesizable successor of the trap/mret console monitor. It snapshots NUM_CH core data channels when is_trap or is_mret rises.

---
 rtl/trap_log_pkg.sv | 50 +++++
 rtl/trap_snap_fifo.sv | 44 ++++
 rtl/trap_event_logger.sv | 172 +++++++++++++++++
 tb/tb_trap_event_logger.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_log_pkg.sv
// Shared types and header layout for the trap/mret snapshot logger.
package trap_log_pkg;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_TRAP = 2'b01,
    EV_MRET = 2'b10
  } ev_type_e;

  localparam int HDR_TYPE_LSB = 30;
  localparam int HDR_TYPE_MSB = 31;
  localparam int HDR_SEQ_LSB  = 16;
  localparam int HDR_SEQ_MSB  = 29;
  localparam int HDR_CNT_LSB  = 8;
  localparam int HDR_CNT_MSB  = 15;
  localparam int HDR_PEND_LSB = 0;
  localparam int HDR_PEND_MSB = 7;

  localparam int SEQ_W  = HDR_SEQ_MSB - HDR_SEQ_LSB + 1;
  localparam int CNT_W  = HDR_CNT_MSB - HDR_CNT_LSB + 1;
  localparam int PEND_W = HDR_PEND_MSB - HDR_PEND_LSB + 1;
  localparam int DROP_W = 16;

  localparam int DEF_NUM_CH = 10;
  localparam int DEF_DATA_W = 32;

  // Reference layout at default sizes; instances rebuild it with their own widths.
  typedef struct packed {
    ev_type_e                             typ;
    logic [DEF_NUM_CH*DEF_DATA_W-1:0]     data;
  } snapshot_t;

  function automatic int snap_width(input int num_ch, input int data_w);
    return $bits(ev_type_e) + num_ch * data_w;
  endfunction

  function automatic logic [31:0] make_header(input ev_type_e          typ,
                                              input logic [SEQ_W-1:0]  seq,
                                              input logic [CNT_W-1:0]  cnt,
                                              input logic [PEND_W-1:0] pend);
    logic [31:0] h;
    h = '0;
    h[HDR_TYPE_MSB:HDR_TYPE_LSB] = typ;
    h[HDR_SEQ_MSB:HDR_SEQ_LSB]   = seq;
    h[HDR_CNT_MSB:HDR_CNT_LSB]   = cnt;
    h[HDR_PEND_MSB:HDR_PEND_LSB] = pend;
    return h;
  endfunction

endpackage

// File: rtl/trap_snap_fifo.sv
// Show-ahead synchronous FIFO holding captured snapshots; dout is the current head.
module trap_snap_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/trap_event_logger.sv
// Captures channel snapshots on trap/mret rising edges and streams them as
// header+payload records over a valid/ready word interface.
module trap_event_logger
  import trap_log_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     is_trap,
  input  logic                     is_mret,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     busy
);

  typedef struct packed {
    ev_type_e                   typ;
    logic [NUM_CH*DATA_W-1:0]   data;
  } snap_t;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_e;

  localparam int SNAP_W = snap_width(NUM_CH, DATA_W);
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  state_e              state;
  state_e              state_next;
  logic                trap_q;
  logic                mret_q;
  logic                trap_ev;
  logic                mret_ev;
  logic                ev_any;
  snap_t               wr_snap;
  snap_t               head;
  logic [SNAP_W-1:0]   head_bits;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LVL_W-1:0]    fifo_level;
  logic [1:0]          n_drop;
  logic [DROP_W:0]     drop_sum;
  logic [PEND_W:0]     pend_sum;
  logic [PEND_W-1:0]   pend_drop;
  logic [SEQ_W-1:0]    seq;
  logic [CNT_W-1:0]    pay_cnt;
  logic [CNT_W-1:0]    word_idx;
  logic [CNT_W-1:0]    word_idx_next;
  logic [DATA_W-1:0]   pay_word;
  logic                accept;
  logic                hdr_accept;
  logic                more;

  assign trap_ev = is_trap & ~trap_q;
  assign mret_ev = is_mret & ~mret_q;
  assign ev_any  = trap_ev | mret_ev;

  // A coincident mret loses to the trap; a full FIFO loses whatever arrived.
  assign fifo_push = ev_any & ~fifo_full;
  assign n_drop    = {1'b0, trap_ev & mret_ev} + {1'b0, ev_any & fifo_full};

  always_comb begin
    wr_snap.typ  = trap_ev ? EV_TRAP : EV_MRET;
    wr_snap.data = data_in;
  end

  // The head stays in the FIFO until its last word is accepted, so DEPTH
  // bounds every buffered snapshot including the record on the wire.
  trap_snap_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SNAP_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_snap),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign head       = snap_t'(head_bits);
  assign pay_cnt    = (head.typ == EV_TRAP) ? CNT_W'(NUM_CH) : CNT_W'(1);
  assign out_valid  = (state != S_IDLE);
  assign accept     = out_valid & out_ready;
  assign hdr_accept = accept & (state == S_HDR);
  assign out_last   = (state == S_DATA) && (word_idx == pay_cnt - CNT_W'(1));
  assign fifo_pop   = accept & out_last;
  assign more       = (fifo_level > LVL_W'(1)) | fifo_push;
  assign busy       = ~fifo_empty | (state != S_IDLE);

  always_comb begin
    pay_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (word_idx == CNT_W'(k)) pay_word = head.data[k*DATA_W +: DATA_W];
    end
  end

  // The pend_drop field tracks the live count until the header is taken.
  always_comb begin
    out_data = '0;
    case (state)
      S_HDR:   out_data = DATA_W'(make_header(head.typ, seq, pay_cnt, pend_drop));
      S_DATA:  out_data = pay_word;
      default: out_data = '0;
    endcase
  end

  always_comb begin
    state_next    = state;
    word_idx_next = word_idx;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_next = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          state_next    = S_DATA;
          word_idx_next = '0;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (out_last) state_next = more ? S_HDR : S_IDLE;
          else          word_idx_next = word_idx + CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      word_idx <= '0;
      trap_q   <= 1'b0;
      mret_q   <= 1'b0;
      seq      <= '0;
    end else begin
      state    <= state_next;
      word_idx <= word_idx_next;
      trap_q   <= is_trap;
      mret_q   <= is_mret;
      if (hdr_accept) seq <= seq + SEQ_W'(1);
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(n_drop);
  assign pend_sum = {1'b0, pend_drop} + (PEND_W+1)'(n_drop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt  <= '0;
      pend_drop <= '0;
    end else begin
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      if (hdr_accept)         pend_drop <= PEND_W'(n_drop);
      else if (pend_sum[PEND_W]) pend_drop <= '1;
      else                    pend_drop <= pend_sum[PEND_W-1:0];
    end
  end

endmodule

// File: tb/tb_trap_event_logger.sv
// Directed bench for trap_event_logger: vector table plus multi-cycle sequences.
module tb_trap_event_logger;

  localparam int NUM_CH = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     is_trap;
  logic                     is_mret;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [15:0]              drop_cnt;
  logic                     busy;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        trap;
    logic        mret;
    logic [31:0] ch0;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_busy;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  vec_t  vecs [18];
  word_t exp_q [$];

  always #5 clk = ~clk;

  trap_event_logger #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .is_trap   (is_trap),
    .is_mret   (is_mret),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    is_trap       = v.trap;
    is_mret       = v.mret;
    data_in[31:0] = v.ch0;
    out_ready     = 1'b1;
  endtask

  task automatic set_data(input int base);
    for (int k = 0; k < NUM_CH; k++) data_in[k*DATA_W +: DATA_W] = 32'(base + k);
  endtask

  task automatic get_word(input string name, output logic [31:0] d, output logic l, output bit ok);
    int n;
    ok = 1'b0;
    d  = '0;
    l  = 1'b0;
    n  = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (out_valid === 1'b1) begin
      d  = out_data;
      l  = out_last;
      ok = 1'b1;
      step();
    end else begin
      tests++;
      failed++;
      $display("[TB] FAIL %s: out_valid still 0 after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic expect_record(input string name, input logic [31:0] hdr, input int base, input int nwords);
    logic [31:0] d;
    logic        l;
    bit          ok;
    get_word({name, " hdr"}, d, l, ok);
    if (!ok) return;
    checkOutput({name, " hdr"}, d, hdr);
    checkOutput({name, " hdr last"}, 32'(l), 32'd0);
    for (int i = 0; i < nwords; i++) begin
      get_word($sformatf("%s w%0d", name, i), d, l, ok);
      if (!ok) return;
      checkOutput($sformatf("%s w%0d", name, i), d, 32'(base + i));
      checkOutput($sformatf("%s w%0d last", name, i), 32'(l), 32'(i == nwords - 1));
    end
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    is_trap   = 1'b0;
    is_mret   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        stalled;
    logic [31:0] held;
    logic [31:0] w;
    word_t       got;

    rstn      = 1'b0;
    is_trap   = 1'b0;
    is_mret   = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    step();
    step();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    checkOutput("reset drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rstn = 1'b1;

    // Trap record then a held mret that follows back-to-back.
    vecs[0] = '{1'b1, 1'b0, 32'd100, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 32'd100, 1'b1, 32'h4000_0A00, 1'b0, 1'b1};
    for (int i = 2; i <= 11; i++)
      vecs[i] = '{1'b0, 1'b0, 32'd100, 1'b1, 32'(98 + i), (i == 11), 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'hDEAD, 1'b1, 32'h8001_0100, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'hDEAD, 1'b1, 32'h0000_DEAD, 1'b1, 1'b1};
    for (int i = 14; i <= 16; i++)
      vecs[i] = '{1'b0, 1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 32'hDEAD, 1'b0, 32'h0, 1'b0, 1'b0};

    set_data(100);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d data", i), out_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d last", i), 32'(out_last), 32'(vecs[i].exp_last));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end
    checkOutput("vec drop_cnt", 32'(drop_cnt), 32'd0);

    // Simultaneous trap and mret rise: trap kept, mret dropped.
    set_data(100);
    is_trap = 1'b1;
    is_mret = 1'b1;
    step();
    is_trap = 1'b0;
    is_mret = 1'b0;
    checkOutput("simul drop_cnt", 32'(drop_cnt), 32'd1);
    expect_record("simul", 32'h4002_0A01, 100, 10);
    step();
    step();
    checkOutput("simul single record", 32'(out_valid), 32'd0);

    // Ten traps into a stalled sink.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_data((i + 1) * 1000);
      is_trap = 1'b1;
      step();
      is_trap = 1'b0;
      step();
    end
    checkOutput("burst drop_cnt", 32'(drop_cnt), 32'd2);
    checkOutput("burst stalled hdr", out_data, 32'h4000_0A02);
    checkOutput("burst busy", 32'(busy), 32'd1);
    for (int j = 0; j < 8; j++)
      expect_record($sformatf("burst rec%0d", j),
                    32'h4000_0A00 | (32'(j) << 16) | ((j == 0) ? 32'd2 : 32'd0),
                    (j + 1) * 1000, 10);
    step();
    step();
    step();
    checkOutput("burst no extra record", 32'(out_valid), 32'd0);

    // Random ready stalls against a scoreboard of expected words.
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 600 && (c < 6 || exp_q.size() > 0); c++) begin
      is_trap = (c == 0 || c == 4);
      is_mret = (c == 2);
      if (c == 0 || c == 4) begin
        exp_q.push_back('{(c == 0) ? 32'h4008_0A00 : 32'h400A_0A00, 1'b0});
        for (int k = 0; k < NUM_CH; k++) begin
          w = $urandom();
          data_in[k*DATA_W +: DATA_W] = w;
          exp_q.push_back('{w, (k == NUM_CH - 1)});
        end
      end
      if (c == 2) begin
        w = $urandom();
        data_in[31:0] = w;
        exp_q.push_back('{32'h8009_0100, 1'b0});
        exp_q.push_back('{w, 1'b1});
      end
      if (stalled) begin
        checkOutput($sformatf("stall c%0d valid", c), 32'(out_valid), 32'd1);
        checkOutput($sformatf("stall c%0d data", c), out_data, held);
      end
      out_ready = 1'($urandom_range(0, 1));
      stalled   = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("[TB] FAIL stall unexpected word: got 0x%08h, expected none", out_data);
          end else begin
            got = exp_q.pop_front();
            checkOutput($sformatf("stall c%0d word", c), out_data, got.d);
            checkOutput($sformatf("stall c%0d last", c), 32'(out_last), 32'(got.l));
          end
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end
      step();
    end
    is_trap = 1'b0;
    is_mret = 1'b0;
    checkOutput("stall words left", 32'(exp_q.size()), 32'd0);

    // Reset asserted while payload word 4 is on the wire.
    out_ready = 1'b1;
    set_data(100);
    is_trap = 1'b1;
    step();
    is_trap = 1'b0;
    begin
      logic [31:0] d;
      logic        l;
      bit          ok;
      get_word("midrst hdr", d, l, ok);
      if (ok) checkOutput("midrst hdr", d, 32'h400B_0A00);
      for (int i = 0; i < 4; i++) begin
        get_word($sformatf("midrst w%0d", i), d, l, ok);
        if (ok) checkOutput($sformatf("midrst w%0d", i), d, 32'(100 + i));
      end
    end
    checkOutput("midrst w4 shown", out_data, 32'd104);
    rstn = 1'b0;
    #1;
    checkOutput("midrst valid", 32'(out_valid), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    step();
    step();
    rstn = 1'b1;
    checkOutput("midrst drop_cnt", 32'(drop_cnt), 32'd0);
    step();
    step();
    step();
    checkOutput("midrst no resume", 32'(out_valid), 32'd0);
    is_trap = 1'b1;
    step();
    is_trap = 1'b0;
    expect_record("post-reset", 32'h4000_0A00, 100, 10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
